// File: rtl/lr3_disp_scan_rx.sv
// Display scan receiver: samples the active-low CAT/AN lines on each DISP_CE and decodes the lit digit to a hex nibble.
// Latency: a commit is registered on the CE edge of the STABLE_N-th matching sample; the frame is published one CLK after the last seen bit is set.
// Backpressure: none; the receiver always accepts samples. DATA_O/BLANK_O hold between frames.
module lr3_disp_scan_rx #(
  parameter int DIGITS   = 8,
  parameter int STABLE_N = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  DISP_CE,
  input  logic [6:0]            CAT,
  input  logic [DIGITS-1:0]     AN,
  output logic [4*DIGITS-1:0]   DATA_O,
  output logic [DIGITS-1:0]     BLANK_O,
  output logic                  FRAME_VLD,
  output logic                  SEG_ERR,
  output logic                  AN_ERR
);

  localparam int          IDX_W      = $clog2(DIGITS);
  localparam logic [3:0]  STABLE_CNT = 4'(STABLE_N);

  // sample tracking state
  logic [DIGITS+6:0]            r_prev;
  logic [3:0]                   r_cnt;
  logic                         r_committed;

  // working frame state
  logic [DIGITS-1:0][3:0]       r_digit;
  logic [DIGITS-1:0]            r_blank;
  logic [DIGITS-1:0]            r_seen;

  // published frame and pulses
  logic [4*DIGITS-1:0]          r_data;
  logic [DIGITS-1:0]            r_blank_out;
  logic                         r_frame_vld;
  logic                         r_seg_err;
  logic                         r_an_err;

  logic [3:0]                   w_lows;
  logic [IDX_W-1:0]             w_idx;
  logic                         w_an_ok;
  logic [DIGITS+6:0]            w_sample;
  logic                         w_same;
  logic [3:0]                   w_cnt_nxt;
  logic                         w_cmt_eff;
  logic                         w_commit;
  logic [3:0]                   w_nib;
  logic                         w_dec_ok;
  logic                         w_is_blank;
  logic                         w_frame_done;
  logic [DIGITS-1:0]            w_seen_base;

  // Count low anode bits and locate the active digit; valid only when exactly one is low.
  always_comb begin
    w_lows = 4'd0;
    w_idx  = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!AN[i]) begin
        w_lows = w_lows + 4'd1;
        w_idx  = i[IDX_W-1:0];
      end
    end
    w_an_ok = (w_lows == 4'd1);
  end

  // Stability tracking: a run is one unchanged {AN,CAT} sample, committed once when it reaches STABLE_N.
  always_comb begin
    w_sample  = {AN, CAT};
    w_same    = (w_sample == r_prev);
    w_cnt_nxt = 4'd1;
    if (w_same) begin
      w_cnt_nxt = (r_cnt == 4'hF) ? r_cnt : r_cnt + 4'd1;
    end
    w_cmt_eff = w_same ? r_committed : 1'b0;
    w_commit  = DISP_CE && w_an_ok && (w_cnt_nxt == STABLE_CNT) && !w_cmt_eff;
  end

  // Segment decode, CAT is {g..a} active-low; 7F is an unlit (blank) digit.
  always_comb begin
    w_nib      = 4'h0;
    w_dec_ok   = 1'b1;
    w_is_blank = 1'b0;
    case (CAT)
      7'h40: w_nib = 4'h0;
      7'h79: w_nib = 4'h1;
      7'h24: w_nib = 4'h2;
      7'h30: w_nib = 4'h3;
      7'h19: w_nib = 4'h4;
      7'h12: w_nib = 4'h5;
      7'h02: w_nib = 4'h6;
      7'h78: w_nib = 4'h7;
      7'h00: w_nib = 4'h8;
      7'h10: w_nib = 4'h9;
      7'h08: w_nib = 4'hA;
      7'h03: w_nib = 4'hB;
      7'h46: w_nib = 4'hC;
      7'h21: w_nib = 4'hD;
      7'h06: w_nib = 4'hE;
      7'h0E: w_nib = 4'hF;
      7'h7F: w_is_blank = 1'b1;
      default: w_dec_ok = 1'b0;
    endcase
  end

  // The seen mask clears on frame transfer; a commit in that same cycle lands in the next frame.
  always_comb begin
    w_frame_done = (r_seen == {DIGITS{1'b1}});
    w_seen_base  = w_frame_done ? '0 : r_seen;
  end

  // Sample tracker: bad AN discards the sample and restarts the run without touching prev.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_prev      <= '0;
      r_cnt       <= 4'd0;
      r_committed <= 1'b0;
      r_an_err    <= 1'b0;
    end else begin
      r_an_err <= 1'b0;
      if (DISP_CE) begin
        if (!w_an_ok) begin
          r_an_err    <= 1'b1;
          r_cnt       <= 4'd0;
          r_committed <= 1'b0;
        end else begin
          r_prev      <= w_sample;
          r_cnt       <= w_cnt_nxt;
          r_committed <= w_cmt_eff | w_commit;
        end
      end
    end
  end

  // Working frame update on commit, and publication once every digit has been seen.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_digit     <= '0;
      r_blank     <= '0;
      r_seen      <= '0;
      r_data      <= '0;
      r_blank_out <= '0;
      r_frame_vld <= 1'b0;
      r_seg_err   <= 1'b0;
    end else begin
      r_frame_vld <= 1'b0;
      r_seg_err   <= 1'b0;
      if (w_frame_done) begin
        r_data      <= r_digit;
        r_blank_out <= r_blank;
        r_frame_vld <= 1'b1;
      end
      r_seen <= w_seen_base;
      if (w_commit) begin
        if (w_dec_ok) begin
          r_digit[w_idx] <= w_nib;
          r_blank[w_idx] <= w_is_blank;
          r_seen         <= w_seen_base | (DIGITS'(1) << w_idx);
        end else begin
          r_seg_err <= 1'b1;
        end
      end
    end
  end

  assign DATA_O    = r_data;
  assign BLANK_O   = r_blank_out;
  assign FRAME_VLD = r_frame_vld;
  assign SEG_ERR   = r_seg_err;
  assign AN_ERR    = r_an_err;

endmodule

// File: tb/tb_lr3_disp_scan_rx.sv
// Directed bench for lr3_disp_scan_rx: scans hand-built frames and checks the published frame and error pulses.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// Pulse counters run in a monitor; each scenario compares deltas against hand-computed expectations.
module tb_lr3_disp_scan_rx;

  logic        CLK;
  logic        RST;
  logic        DISP_CE;
  logic [6:0]  CAT;
  logic [7:0]  AN;
  logic [31:0] DATA_O;
  logic [7:0]  BLANK_O;
  logic        FRAME_VLD;
  logic        SEG_ERR;
  logic        AN_ERR;

  int n_asserts;
  int n_fail;
  int n_frames;
  int n_seg;
  int n_an;

  lr3_disp_scan_rx #(.DIGITS(8), .STABLE_N(2)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .DISP_CE   (DISP_CE),
    .CAT       (CAT),
    .AN        (AN),
    .DATA_O    (DATA_O),
    .BLANK_O   (BLANK_O),
    .FRAME_VLD (FRAME_VLD),
    .SEG_ERR   (SEG_ERR),
    .AN_ERR    (AN_ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Count the high cycles of each pulse output; a stretched pulse shows up as an extra count.
  initial begin
    n_frames = 0;
    n_seg    = 0;
    n_an     = 0;
  end
  always @(negedge CLK) begin
    if (FRAME_VLD) n_frames++;
    if (SEG_ERR)   n_seg++;
    if (AN_ERR)    n_an++;
  end

  function automatic logic [6:0] seg(input int v);
    case (v)
      0: seg = 7'h40;  1: seg = 7'h79;  2: seg = 7'h24;  3: seg = 7'h30;
      4: seg = 7'h19;  5: seg = 7'h12;  6: seg = 7'h02;  7: seg = 7'h78;
      8: seg = 7'h00;  9: seg = 7'h10;  10: seg = 7'h08; 11: seg = 7'h03;
      12: seg = 7'h46; 13: seg = 7'h21; 14: seg = 7'h06; 15: seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
  endfunction

  // n CE samples of one raw {AN,CAT}, CE held high back-to-back.
  task automatic drive_raw(input logic [7:0] an, input logic [6:0] cat, input int n);
    repeat (n) begin
      @(negedge CLK);
      AN      = an;
      CAT     = cat;
      DISP_CE = 1'b1;
    end
  endtask

  task automatic drive_digit(input int idx, input logic [6:0] cat, input int n);
    drive_raw(~(8'b1 << idx), cat, n);
  endtask

  task automatic idle(input int n);
    @(negedge CLK);
    DISP_CE = 1'b0;
    AN      = 8'hFF;
    CAT     = 7'h7F;
    repeat (n) @(negedge CLK);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    DISP_CE = 1'b0;
    RST     = 1'b0;
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_reset();
    RST     = 1'b0;
    DISP_CE = 1'b1;
    AN      = 8'hFE;
    CAT     = 7'h40;
    repeat (4) @(negedge CLK);
    n_asserts += 5;
    if (DATA_O !== 32'h0)   begin n_fail++; $display("FAIL reset_data got %h want 00000000", DATA_O); end
    if (BLANK_O !== 8'h0)   begin n_fail++; $display("FAIL reset_blank got %h want 00", BLANK_O); end
    if (FRAME_VLD !== 1'b0) begin n_fail++; $display("FAIL reset_frame_vld got %b want 0", FRAME_VLD); end
    if (SEG_ERR !== 1'b0)   begin n_fail++; $display("FAIL reset_seg_err got %b want 0", SEG_ERR); end
    if (AN_ERR !== 1'b0)    begin n_fail++; $display("FAIL reset_an_err got %b want 0", AN_ERR); end
    DISP_CE = 1'b0;
    RST     = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_basic_frame();
    int f0, s0, a0;
    f0 = n_frames; s0 = n_seg; a0 = n_an;
    for (int d = 0; d < 7; d++) drive_digit(d, seg(d), 3);
    drive_digit(7, seg(7), 2);
    // The last commit edge has just passed: the frame must not be out yet.
    @(negedge CLK);
    DISP_CE = 1'b0;
    n_asserts++;
    if (FRAME_VLD !== 1'b0) begin n_fail++; $display("FAIL basic_vld_early got %b want 0", FRAME_VLD); end
    @(negedge CLK);
    n_asserts++;
    if (FRAME_VLD !== 1'b1) begin n_fail++; $display("FAIL basic_vld_on_time got %b want 1", FRAME_VLD); end
    idle(3);
    n_asserts += 5;
    if (n_frames - f0 !== 1)  begin n_fail++; $display("FAIL basic_frames got %0d want 1", n_frames - f0); end
    if (DATA_O !== 32'h76543210) begin n_fail++; $display("FAIL basic_data got %h want 76543210", DATA_O); end
    if (BLANK_O !== 8'h00)    begin n_fail++; $display("FAIL basic_blank got %h want 00", BLANK_O); end
    if (n_seg - s0 !== 0)     begin n_fail++; $display("FAIL basic_seg_err got %0d want 0", n_seg - s0); end
    if (n_an - a0 !== 0)      begin n_fail++; $display("FAIL basic_an_err got %0d want 0", n_an - a0); end
  endtask

  task automatic test_blank_and_f();
    int f0;
    do_reset();
    f0 = n_frames;
    for (int d = 0; d < 8; d++) begin
      if (d == 5)      drive_digit(d, 7'h7F, 3);
      else if (d == 2) drive_digit(d, 7'h0E, 3);
      else             drive_digit(d, seg(d), 3);
    end
    idle(3);
    n_asserts += 3;
    if (n_frames - f0 !== 1)     begin n_fail++; $display("FAIL blank_frames got %0d want 1", n_frames - f0); end
    if (DATA_O !== 32'h76043F10) begin n_fail++; $display("FAIL blank_data got %h want 76043f10", DATA_O); end
    if (BLANK_O !== 8'h20)       begin n_fail++; $display("FAIL blank_mask got %h want 20", BLANK_O); end
  endtask

  task automatic test_short_digit();
    int f0;
    do_reset();
    f0 = n_frames;
    for (int d = 0; d < 8; d++) drive_digit(d, seg(d), (d == 3) ? 1 : 3);
    idle(3);
    n_asserts++;
    if (n_frames - f0 !== 0) begin n_fail++; $display("FAIL short_no_frame got %0d want 0", n_frames - f0); end
    drive_digit(3, seg(3), 2);
    idle(3);
    n_asserts += 2;
    if (n_frames - f0 !== 1)     begin n_fail++; $display("FAIL short_frames got %0d want 1", n_frames - f0); end
    if (DATA_O !== 32'h76543210) begin n_fail++; $display("FAIL short_data got %h want 76543210", DATA_O); end
  endtask

  task automatic test_an_err();
    int f0, a0;
    do_reset();
    f0 = n_frames; a0 = n_an;
    for (int d = 0; d < 7; d++) drive_digit(d, seg(d), 3);
    drive_raw(8'hFF, seg(9), 1);
    drive_raw(8'hFC, seg(9), 1);
    idle(3);
    n_asserts += 2;
    if (n_an - a0 !== 2)     begin n_fail++; $display("FAIL an_err_count got %0d want 2", n_an - a0); end
    if (n_frames - f0 !== 0) begin n_fail++; $display("FAIL an_err_no_frame got %0d want 0", n_frames - f0); end
    drive_digit(7, seg(7), 3);
    idle(3);
    n_asserts += 2;
    if (n_frames - f0 !== 1)     begin n_fail++; $display("FAIL an_err_frames got %0d want 1", n_frames - f0); end
    if (DATA_O !== 32'h76543210) begin n_fail++; $display("FAIL an_err_data got %h want 76543210", DATA_O); end
  endtask

  task automatic test_seg_err();
    int f0, s0;
    do_reset();
    f0 = n_frames; s0 = n_seg;
    for (int d = 1; d < 8; d++) drive_digit(d, seg(15 - d), 3);
    drive_digit(0, 7'h55, 5);
    idle(3);
    n_asserts += 2;
    if (n_seg - s0 !== 1)    begin n_fail++; $display("FAIL seg_err_count got %0d want 1", n_seg - s0); end
    if (n_frames - f0 !== 0) begin n_fail++; $display("FAIL seg_err_no_frame got %0d want 0", n_frames - f0); end
    drive_digit(0, seg(12), 3);
    idle(3);
    n_asserts += 2;
    if (n_frames - f0 !== 1)     begin n_fail++; $display("FAIL seg_err_frames got %0d want 1", n_frames - f0); end
    if (DATA_O !== 32'h89ABCDEC) begin n_fail++; $display("FAIL seg_err_data got %h want 89abcdec", DATA_O); end
  endtask

  task automatic test_reset_mid_frame();
    int f0;
    for (int d = 0; d < 5; d++) drive_digit(d, seg(d + 1), 3);
    do_reset();
    n_asserts += 2;
    if (DATA_O !== 32'h0) begin n_fail++; $display("FAIL midrst_data got %h want 00000000", DATA_O); end
    if (BLANK_O !== 8'h0) begin n_fail++; $display("FAIL midrst_blank got %h want 00", BLANK_O); end
    f0 = n_frames;
    // Descending order: any leftover seen bits would publish a mixed frame early.
    for (int d = 7; d >= 0; d--) drive_digit(d, seg(10), 3);
    idle(3);
    n_asserts += 3;
    if (n_frames - f0 !== 1)     begin n_fail++; $display("FAIL midrst_frames got %0d want 1", n_frames - f0); end
    if (DATA_O !== 32'hAAAAAAAA) begin n_fail++; $display("FAIL midrst_data_a got %h want aaaaaaaa", DATA_O); end
    if (BLANK_O !== 8'h00)       begin n_fail++; $display("FAIL midrst_blank_a got %h want 00", BLANK_O); end
  endtask

  initial begin
    n_asserts = 0;
    n_fail    = 0;
    RST       = 1'b0;
    DISP_CE   = 1'b0;
    AN        = 8'hFF;
    CAT       = 7'h7F;
    test_reset();
    test_basic_frame();
    test_blank_and_f();
    test_short_digit();
    test_an_err();
    test_seg_err();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
